menu_ctrl: RTL

Parametrised start-screen menu controller: draws a fixed title, a column of NUM_ITEMS selectable entries ("MAP 1" … "MAP n") and a cursor arrow into the pixel stream, and owns the selection state. Replaces the fixed four-entry menu. Adds auto-repeat on held buttons, a confirm/back lock, a one-cycle selection strobe and a registered pixel pipeline. Sits between the VGA timing generator (hpos/vpos) and the colour mux feeding the display.

---
 rtl/menu_pkg.sv | 33 +++
 rtl/ascii_rom.sv | 46 ++++
 rtl/menu_nav.sv | 129 ++++++++++++
 rtl/menu_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared glyph codes, title string and FSM state type for the start-screen menu.
package menu_pkg;

  localparam int unsigned GLYPH_W   = 6;
  localparam int unsigned ROM_AW    = 9;
  localparam int unsigned TITLE_LEN = 11;
  localparam int unsigned NUM_BTN   = 4;

  // Button vector bit positions; up/down double as the auto-repeat direction index.
  localparam int unsigned BTN_UP      = 0;
  localparam int unsigned BTN_DOWN    = 1;
  localparam int unsigned BTN_CONFIRM = 2;
  localparam int unsigned BTN_BACK    = 3;

  typedef logic [GLYPH_W-1:0] glyph_t;

  localparam glyph_t GLYPH_ARROW  = 6'd0;
  localparam glyph_t GLYPH_DIGIT0 = 6'd1;
  localparam glyph_t GLYPH_A      = 6'd11;
  localparam glyph_t GLYPH_SPACE  = 6'd37;

  function automatic glyph_t letter(input logic [7:0] ch);
    return GLYPH_A + 6'(ch - 8'h41);
  endfunction

  localparam glyph_t TITLE [TITLE_LEN] = '{
    letter("B"), letter("A"), letter("T"), letter("T"), letter("L"), letter("E"),
    GLYPH_SPACE, letter("C"), letter("I"), letter("T"), letter("Y")
  };

  typedef enum logic {BROWSE, LOCKED} menu_state_t;

endpackage

// File: rtl/ascii_rom.sv
// 8x8 glyph ROM, combinational read; address is {glyph code, row}, bit 7 is the leftmost pixel.
module ascii_rom
  import menu_pkg::*;
(
  input  logic [ROM_AW-1:0] addr_i,
  output logic [7:0]        data_o
);

  glyph_t      glyph;
  logic [2:0]  row;
  logic [63:0] bitmap;

  assign glyph = addr_i[ROM_AW-1:3];
  assign row   = addr_i[2:0];

  always_comb begin
    bitmap = '0;
    case (glyph)
      GLYPH_ARROW:         bitmap = 64'h10_18_FC_FE_FC_18_10_00;
      GLYPH_DIGIT0:        bitmap = 64'h7C_C6_CE_D6_E6_C6_7C_00;
      GLYPH_DIGIT0 + 6'd1: bitmap = 64'h18_38_18_18_18_18_7E_00;
      GLYPH_DIGIT0 + 6'd2: bitmap = 64'h7C_C6_06_1C_70_C6_FE_00;
      GLYPH_DIGIT0 + 6'd3: bitmap = 64'h7C_C6_06_3C_06_C6_7C_00;
      GLYPH_DIGIT0 + 6'd4: bitmap = 64'h1C_3C_6C_CC_FE_0C_1E_00;
      GLYPH_DIGIT0 + 6'd5: bitmap = 64'hFE_C0_FC_06_06_C6_7C_00;
      GLYPH_DIGIT0 + 6'd6: bitmap = 64'h38_60_C0_FC_C6_C6_7C_00;
      GLYPH_DIGIT0 + 6'd7: bitmap = 64'hFE_C6_0C_18_30_30_30_00;
      GLYPH_DIGIT0 + 6'd8: bitmap = 64'h7C_C6_C6_7C_C6_C6_7C_00;
      GLYPH_DIGIT0 + 6'd9: bitmap = 64'h7C_C6_C6_7E_06_0C_78_00;
      GLYPH_A:             bitmap = 64'h38_6C_C6_C6_FE_C6_C6_00;
      letter("B"):         bitmap = 64'hFC_66_66_7C_66_66_FC_00;
      letter("C"):         bitmap = 64'h3C_66_C0_C0_C0_66_3C_00;
      letter("E"):         bitmap = 64'hFE_62_68_78_68_62_FE_00;
      letter("I"):         bitmap = 64'h3C_18_18_18_18_18_3C_00;
      letter("L"):         bitmap = 64'hF0_60_60_60_62_66_FE_00;
      letter("M"):         bitmap = 64'hC6_EE_FE_FE_D6_C6_C6_00;
      letter("P"):         bitmap = 64'hFC_66_66_7C_60_60_F0_00;
      letter("T"):         bitmap = 64'h7E_5A_18_18_18_18_3C_00;
      letter("Y"):         bitmap = 64'h66_66_66_3C_18_18_3C_00;
      default:             bitmap = '0;
    endcase
  end

  assign data_o = bitmap[{~row, 3'b000} +: 8];

endmodule

// File: rtl/menu_nav.sv
// Menu navigation: button edge detection, per-direction auto-repeat, BROWSE/LOCKED FSM and selection state.
module menu_nav
  import menu_pkg::*;
#(
  parameter int unsigned NUM_ITEMS     = 4,
  parameter int unsigned REPEAT_DELAY  = 12_500_000,
  parameter int unsigned REPEAT_PERIOD = 3_125_000
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         up_i,
  input  logic                         down_i,
  input  logic                         confirm_i,
  input  logic                         back_i,
  output logic [$clog2(NUM_ITEMS)-1:0] sel_o,
  output logic                         sel_valid_o,
  output logic                         locked_o
);

  localparam int unsigned SEL_W = $clog2(NUM_ITEMS);
  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_ITEMS - 1);

  logic [NUM_BTN-1:0] btn_cur_q, btn_prev_q, press;
  logic [1:0]         step;
  logic               both_held;
  menu_state_t        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;

  assign press     = btn_cur_q & ~btn_prev_q;
  assign both_held = btn_cur_q[BTN_UP] & btn_cur_q[BTN_DOWN];

  // Held-through-reset buttons read as already pressed, so they need a fresh press.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      btn_cur_q  <= '1;
      btn_prev_q <= '1;
    end else begin
      btn_cur_q  <= {back_i, confirm_i, down_i, up_i};
      btn_prev_q <= btn_cur_q;
    end
  end

  // cnt counts cycles since the last step; rep selects the initial delay or the repeat period.
  for (genvar d = 0; d < 2; d++) begin : g_rep
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d, step_c;

    always_comb begin
      cnt_d  = cnt_q;
      rep_d  = rep_q;
      step_c = 1'b0;
      if (state_q != BROWSE || !btn_cur_q[d] || both_held) begin
        cnt_d = '0;
        rep_d = 1'b0;
      end else if (press[d]) begin
        cnt_d  = CNT_W'(1);
        step_c = 1'b1;
      end else if (cnt_q != '0) begin
        if (cnt_q == (rep_q ? PERIOD_C : DELAY_C)) begin
          cnt_d  = CNT_W'(1);
          rep_d  = 1'b1;
          step_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        cnt_q <= '0;
        rep_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        rep_q <= rep_d;
      end
    end

    assign step[d] = step_c;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= BROWSE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BROWSE:  if (press[BTN_CONFIRM]) state_d = LOCKED;
      LOCKED:  if (press[BTN_BACK])    state_d = BROWSE;
      default: state_d = BROWSE;
    endcase
  end

  // Confirm wins over a same-cycle move; opposing steps cancel.
  always_comb begin
    sel_d   = sel_q;
    valid_d = 1'b0;
    if (state_q == BROWSE) begin
      if (press[BTN_CONFIRM]) begin
        valid_d = 1'b1;
      end else if (step[BTN_UP] && !step[BTN_DOWN]) begin
        sel_d = (sel_q == '0) ? SEL_MAX : sel_q - SEL_W'(1);
      end else if (step[BTN_DOWN] && !step[BTN_UP]) begin
        sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign sel_o       = sel_q;
  assign sel_valid_o = valid_q;
  assign locked_o    = (state_q == LOCKED);

endmodule

// File: rtl/menu_ctrl.sv
// Start-screen menu: title, NUM_ITEMS "MAP n" entries and a cursor, drawn through a 2-stage pixel pipeline.
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int unsigned            COLOR_BITS    = 24,
  parameter int unsigned            NUM_ITEMS     = 4,
  parameter int unsigned            ROW0          = 9,
  parameter int unsigned            REPEAT_DELAY  = 12_500_000,
  parameter int unsigned            REPEAT_PERIOD = 3_125_000,
  parameter logic [COLOR_BITS-1:0]  FG_COLOR      = 24'h000000,
  parameter logic [COLOR_BITS-1:0]  BG_COLOR      = 24'hE0E0E0,
  parameter logic [COLOR_BITS-1:0]  HL_COLOR      = 24'hE00000
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         up_i,
  input  logic                         down_i,
  input  logic                         confirm_i,
  input  logic                         back_i,
  input  logic [9:0]                   hpos_i,
  input  logic [9:0]                   vpos_i,
  output logic [COLOR_BITS/3-1:0]      menu_red_o,
  output logic [COLOR_BITS/3-1:0]      menu_green_o,
  output logic [COLOR_BITS/3-1:0]      menu_blue_o,
  output logic [$clog2(NUM_ITEMS)-1:0] sel_o,
  output logic                         sel_valid_o,
  output logic                         locked_o
);

  localparam int unsigned CH_W = COLOR_BITS / 3;

  logic [4:0] row5, col5, k5;
  logic [5:0] col4;
  logic [2:0] k, sel3;
  logic       title_rows, entry_rows;
  glyph_t     glyph;
  logic [2:0] grow, xoff;
  logic       in_text, hl;
  logic       unused_pos;

  logic [ROM_AW-1:0]     rom_addr_q;
  logic [7:0]            rom_data;
  logic [2:0]            xoff_q;
  logic                  in_text_q, hl_q;
  logic [COLOR_BITS-1:0] color_q, color_d;

  menu_nav #(
    .NUM_ITEMS     (NUM_ITEMS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_nav (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .up_i        (up_i),
    .down_i      (down_i),
    .confirm_i   (confirm_i),
    .back_i      (back_i),
    .sel_o       (sel_o),
    .sel_valid_o (sel_valid_o),
    .locked_o    (locked_o)
  );

  assign row5       = vpos_i[9:5];
  assign col5       = hpos_i[9:5];
  assign col4       = hpos_i[9:4];
  assign k5         = row5 - 5'(ROW0);
  assign k          = k5[2:0];
  assign sel3       = 3'(sel_o);
  assign title_rows = (vpos_i[9:7] == 3'd1) && (vpos_i[6:5] == 2'd0);
  assign entry_rows = (row5 >= 5'(ROW0)) && (row5 < 5'(ROW0 + NUM_ITEMS)) && !vpos_i[4];
  assign unused_pos = ^{hpos_i[0], vpos_i[0], k5[4:3]};

  // Stage 1 decode: 8x8 glyphs, title at 4x, entries and arrow at 2x in the top half of their row.
  always_comb begin
    glyph   = GLYPH_SPACE;
    grow    = 3'd0;
    xoff    = 3'd0;
    in_text = 1'b0;
    hl      = 1'b0;
    if (title_rows && col5 >= 5'd5 && col5 <= 5'd15) begin
      glyph   = TITLE[4'(col5 - 5'd5)];
      grow    = vpos_i[4:2];
      xoff    = hpos_i[4:2];
      in_text = 1'b1;
    end else if (entry_rows) begin
      grow = vpos_i[3:1];
      xoff = hpos_i[3:1];
      if (col4 == 6'd15 && k == sel3) begin
        glyph   = GLYPH_ARROW;
        in_text = 1'b1;
      end else if (col4 >= 6'd17 && col4 <= 6'd21) begin
        in_text = 1'b1;
        hl      = locked_o && (k == sel3);
        case (col4)
          6'd17:   glyph = letter("M");
          6'd18:   glyph = letter("A");
          6'd19:   glyph = letter("P");
          6'd20:   glyph = GLYPH_SPACE;
          default: glyph = GLYPH_DIGIT0 + 6'(k) + 6'd1;
        endcase
      end
    end
  end

  ascii_rom u_rom (
    .addr_i (rom_addr_q),
    .data_o (rom_data)
  );

  always_comb begin
    color_d = BG_COLOR;
    if (in_text_q && rom_data[~xoff_q]) color_d = hl_q ? HL_COLOR : FG_COLOR;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rom_addr_q <= '0;
      xoff_q     <= '0;
      in_text_q  <= 1'b0;
      hl_q       <= 1'b0;
      color_q    <= '0;
    end else begin
      rom_addr_q <= {glyph, grow};
      xoff_q     <= xoff;
      in_text_q  <= in_text;
      hl_q       <= hl;
      color_q    <= color_d;
    end
  end

  assign menu_red_o   = color_q[COLOR_BITS-1 -: CH_W];
  assign menu_green_o = color_q[COLOR_BITS-CH_W-1 -: CH_W];
  assign menu_blue_o  = color_q[CH_W-1:0];

endmodule
